lzc_norm_pipe: RTL
==================

// Module: lzc_norm_pipe
// PURPOSE
//  Parametrised, pipelined leading-zero / leading-sign counter with normalising left shift.
//  Feeds FP add/sub and int-to-FP normalisation in the vfpu datapath.
//  Two register stages with valid/ready backpressure.
//  Per-transaction mode: leading zeros (unsigned) or redundant sign bits (two's complement).
// PARAMETERS
//  WIDTH   32   operand width, >=2, any integer (not restricted to powers of 2)
//  CNT_W   $clog2(WIDTH+1)   count width (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      input transaction present
//  in_ready   out  1      block can accept this cycle
//  in_data    in   WIDTH  operand
//  in_mode    in   1      0 = count leading zeros; 1 = count redundant sign bits
//  out_valid  out  1      result present
//  out_ready  in   1      downstream accepts result
//  out_count  out  CNT_W  shift amount applied
//  out_norm   out  WIDTH  in_data << out_count, zero-filled
//  out_zero   out  1      mode0: operand == 0; mode1: operand all-0 or all-1
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all stage valids=0, out_valid=0, out_count=0, out_norm=0, out_zero=0.
//  in_ready=0 while rst_n=0; first accept is possible on the first cycle after reset deasserts.
//  Handshake:
//   - Transfer occurs when valid&&ready on the same edge.
//   - out_valid/out_* are held stable until accepted.
//   - in_ready must not depend on in_valid.
//  Pipeline:
//   - S1 registers in_data/in_mode on accept.
//   - S2 registers count, norm and zero computed from S1.
//   - Latency: accept at edge N -> out_valid=1 after edge N+1.
//  Advance rules:
//   - s2_en = ~s2_valid | out_ready.
//   - s1_en = ~s1_valid | s2_en.
//   - in_ready = s1_en.
//  Throughput: 1 result/cycle while out_ready=1; no bubbles, no drops, no duplicates.
//  Stall: out_ready=0 with both stages full -> in_ready=0 and all registers hold.
//  Simultaneous events: out accept and in accept in the same cycle are both legal at full rate.
//  Mode 0: count = number of leading 0s from the MSB.
//   - All-zero operand -> count=WIDTH, norm=0, zero=1.
//  Mode 1: count = (number of leading bits equal to the MSB) - 1.
//   - All-0 or all-1 operand -> count=WIDTH-1, zero=1, norm=in_data<<(WIDTH-1).
//  Shift: out_norm = in_data << out_count, truncated to WIDTH bits. In mode 0 with zero=0, norm[WIDTH-1]=1.
//  Count logic: tree-structured (pairwise 2:1 merge of sub-block counts, padded to the next power of 2 with 1s).
//   - Padding must not alter the result for non-power-of-2 WIDTH.
//   - No priority chains longer than log2.
//  Reset mid-operation: in-flight data is discarded; no output is produced for it after reset releases.
// TESTING (WIDTH=32 unless noted)
//  1 Mode0, 0x0000_0001, out_ready=1 -> 2 cycles later out_count=31, out_norm=0x8000_0000, out_zero=0.
//  2 Mode0, 0x0000_0000 -> count=32, norm=0, zero=1.
//    Mode1, 0xFFFF_FFFF -> count=31, norm=0x8000_0000, zero=1.
//  3 Mode1, 0xFFFF_F000 -> count=19, norm=0x8000_0000.
//    Mode1, 0x0000_4000 -> count=16, norm=0x4000_0000, zero=0.
//  4 Back-to-back stream of 8 operands, out_ready toggling 1,0,0,1,...
//    -> order kept, no loss; in_ready=0 exactly when both stages are full and out_ready=0.
//  5 Stream in flight, rst_n=0 for 1 cycle -> out_valid=0 next cycle; no stale results after release.
//  6 WIDTH=24, exhaustive single-hot plus random vs reference model.
//    -> 0x000001: count=23; 0x000000: count=24.

Source files
------------

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero / redundant-sign counter with normalising left shift.
// S1 captures the operand; S2 holds the tree count, normalised value and zero flag.
module lzc_norm_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero
);

  // The tree spans 2**CNT_W >= WIDTH+1 leaves, so at least one padding 1 always
  // terminates the search and an all-zero operand counts to exactly WIDTH.
  localparam int LVL = CNT_W;
  localparam int P   = 1 << LVL;

  function automatic logic [CNT_W-1:0] lzc_tree(input logic [WIDTH-1:0] vec);
    logic [P-1:0]     pad;
    logic [CNT_W-1:0] cnt [LVL+1][P];
    logic             hit [LVL+1][P];
    pad = '1;
    pad[P-1 -: WIDTH] = vec;
    for (int l = 0; l <= LVL; l++) begin
      for (int i = 0; i < P; i++) begin
        cnt[l][i] = '0;
        hit[l][i] = 1'b0;
      end
    end
    for (int i = 0; i < P; i++) hit[0][i] = pad[P-1-i];
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < (P >> (l + 1)); i++) begin
        hit[l+1][i] = hit[l][2*i] | hit[l][2*i+1];
        cnt[l+1][i] = hit[l][2*i] ? cnt[l][2*i] : (cnt[l][2*i+1] | CNT_W'(1 << l));
      end
    end
    return hit[LVL][0] ? cnt[LVL][0] : CNT_W'(WIDTH);
  endfunction

  logic             vld_p1_q, vld_p2_q;
  logic [WIDTH-1:0] data_p1_q;
  logic             mode_p1_q;
  logic [CNT_W-1:0] cnt_p2_q, cnt_p2_d;
  logic [WIDTH-1:0] norm_p2_q, norm_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic [WIDTH-1:0] tree_in;
  logic             s1_en, s2_en;

  assign s2_en    = ~vld_p2_q | out_ready;
  assign s1_en    = ~vld_p1_q | s2_en;
  assign in_ready = rst_n & s1_en;

  // ---- S1 -> S2 boundary: mode 1 counts sign transitions between adjacent bits
  always_comb begin
    tree_in   = mode_p1_q ? {data_p1_q[WIDTH-1:1] ^ data_p1_q[WIDTH-2:0], 1'b1} : data_p1_q;
    cnt_p2_d  = lzc_tree(tree_in);
    zero_p2_d = mode_p1_q ? (cnt_p2_d == CNT_W'(WIDTH - 1)) : (cnt_p2_d == CNT_W'(WIDTH));
    norm_p2_d = data_p1_q << cnt_p2_d;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_p1_q <= in_data;
      mode_p1_q <= in_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      cnt_p2_q  <= '0;
      norm_p2_q <= '0;
      zero_p2_q <= 1'b0;
    end else begin
      if (s1_en) vld_p1_q <= in_valid;
      if (s2_en) vld_p2_q <= vld_p1_q;
      if (s2_en && vld_p1_q) begin
        cnt_p2_q  <= cnt_p2_d;
        norm_p2_q <= norm_p2_d;
        zero_p2_q <= zero_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_count = cnt_p2_q;
  assign out_norm  = norm_p2_q;
  assign out_zero  = zero_p2_q;

endmodule
